// File: rtl/wave_pkg.sv
// Shared definitions for the waveform capture path and the waveform display.
// Holds the capture FSM state type and the default RAM geometry, so both
// sides agree on samples per capture and stored sample width.
package wave_pkg;

    // log2 of samples per capture (256 samples per buffer half)
    localparam int unsigned WAVE_SAMPLES_LOG2 = 8;
    // Stored sample width, taken from the top bits of the audio sample
    localparam int unsigned WAVE_DATA_W       = 8;
    // Width of the audio sample produced by music_player
    localparam int unsigned WAVE_SAMPLE_W     = 18;

    typedef enum logic [1:0] {
        ARMED  = 2'd0,
        ACTIVE = 2'd1,
        WAIT   = 2'd2
    } capture_state_t;

endpackage

// File: rtl/zero_cross_detect.sv
// Rising zero-crossing detector for the strobed sample stream.
// Remembers the sign of the last strobed sample and flags a strobe whose
// sample is non-negative while the previous one was negative.
// Ports:
//   clk              system clock
//   reset            asynchronous, active-low reset
//   new_sample_ready 1-cycle strobe: sample_sign is valid
//   sample_sign      sign bit of the strobed sample
//   crossing         combinational: this strobe is a rising zero crossing
module zero_cross_detect (
    input  logic clk,
    input  logic reset,
    input  logic new_sample_ready,
    input  logic sample_sign,
    output logic crossing
);

    logic prev_neg;

    // Tracks every strobe regardless of the capture state, so the next
    // crossing is always judged against the most recent sample.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            prev_neg <= 1'b0;
        end else if (new_sample_ready) begin
            prev_neg <= sample_sign;
        end
    end

    assign crossing = new_sample_ready & prev_neg & ~sample_sign;

endmodule

// File: rtl/wave_capture.sv
// Waveform capture front end between music_player and the waveform RAM.
// Arms on a rising zero crossing, captures NSAMP consecutive samples into
// the half of the double-buffered RAM the display is not reading, then
// waits for the display to go idle before swapping halves and re-arming.
// Ports:
//   clk               system clock
//   reset             asynchronous, active-low reset
//   new_sample_ready  1-cycle strobe: new_sample_in is valid
//   new_sample_in     signed two's-complement audio sample
//   wave_display_idle display is not reading the RAM (level)
//   write_address     {buffer half, index} for the RAM write port
//   write_enable      1-cycle RAM write strobe
//   write_sample      offset-binary sample to store
//   read_index        buffer half the display reads
module wave_capture
    import wave_pkg::*;
#(
    parameter int unsigned SAMPLES_LOG2 = WAVE_SAMPLES_LOG2,
    parameter int unsigned DATA_W       = WAVE_DATA_W
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    new_sample_ready,
    input  logic [WAVE_SAMPLE_W-1:0] new_sample_in,
    input  logic                    wave_display_idle,
    output logic [SAMPLES_LOG2:0]   write_address,
    output logic                    write_enable,
    output logic [DATA_W-1:0]       write_sample,
    output logic                    read_index
);

    localparam logic [SAMPLES_LOG2-1:0] IDX_ZERO = '0;
    localparam logic [SAMPLES_LOG2-1:0] IDX_ONE  = SAMPLES_LOG2'(1);
    localparam logic [SAMPLES_LOG2-1:0] IDX_LAST = '1;

    capture_state_t          state;
    logic [SAMPLES_LOG2-1:0] count;
    logic                    crossing;
    logic [DATA_W-1:0]       sample_data;
    logic                    unused_low_bits;

    zero_cross_detect u_zero_cross (
        .clk              (clk),
        .reset            (reset),
        .new_sample_ready (new_sample_ready),
        .sample_sign      (new_sample_in[WAVE_SAMPLE_W-1]),
        .crossing         (crossing)
    );

    // Top DATA_W bits with the sign inverted: two's complement -> offset binary
    assign sample_data = {~new_sample_in[WAVE_SAMPLE_W-1],
                          new_sample_in[WAVE_SAMPLE_W-2 -: DATA_W-1]};

    // Low sample bits are below the stored resolution
    assign unused_low_bits = ^new_sample_in[WAVE_SAMPLE_W-DATA_W-1:0];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state         <= ARMED;
            count         <= '0;
            read_index    <= 1'b0;
            write_enable  <= 1'b0;
            write_address <= '0;
            write_sample  <= '0;
        end else begin
            write_enable <= 1'b0;
            case (state)
                ARMED: begin
                    if (crossing) begin
                        write_enable  <= 1'b1;
                        write_address <= {~read_index, IDX_ZERO};
                        write_sample  <= sample_data;
                        count         <= IDX_ONE;
                        state         <= ACTIVE;
                    end
                end
                ACTIVE: begin
                    if (new_sample_ready) begin
                        write_enable  <= 1'b1;
                        write_address <= {~read_index, count};
                        write_sample  <= sample_data;
                        // Natural wrap of the counter leaves it at 0 for the next capture
                        count         <= count + IDX_ONE;
                        if (count == IDX_LAST) begin
                            state <= WAIT;
                        end
                    end
                end
                WAIT: begin
                    if (wave_display_idle) begin
                        read_index <= ~read_index;
                        state      <= ARMED;
                    end
                end
                default: begin
                    state <= ARMED;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_wave_capture.sv
module tb_wave_capture;

    logic        clk;
    logic        reset;
    logic        new_sample_ready;
    logic [17:0] new_sample_in;
    logic        wave_display_idle;
    logic [8:0]  write_address;
    logic        write_enable;
    logic [7:0]  write_sample;
    logic        read_index;

    int total;
    int bad;

    typedef struct {
        logic        ready;
        logic [17:0] s;
        logic        idle;
        logic        we;
        logic [8:0]  addr;
        logic [7:0]  data;
        logic        ri;
    } vec_t;

    vec_t tbl[6];

    wave_capture #(.SAMPLES_LOG2(8), .DATA_W(8)) dut (
        .clk               (clk),
        .reset             (reset),
        .new_sample_ready  (new_sample_ready),
        .new_sample_in     (new_sample_in),
        .wave_display_idle (wave_display_idle),
        .write_address     (write_address),
        .write_enable      (write_enable),
        .write_sample      (write_sample),
        .read_index        (read_index)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // One clock: drive inputs on the falling edge, sample outputs 1 after the rising edge
    task automatic step(input string name, input logic rdy, input logic [17:0] s,
                        input logic idle, input logic we, input logic [8:0] addr,
                        input logic [7:0] data, input logic ri);
        @(negedge clk);
        new_sample_ready  = rdy;
        new_sample_in     = s;
        wave_display_idle = idle;
        @(posedge clk);
        #1;
        check({name, ".we"}, int'(write_enable), int'(we));
        if (we) begin
            check({name, ".addr"}, int'(write_address), int'(addr));
            check({name, ".data"}, int'(write_sample), int'(data));
        end
        check({name, ".ri"}, int'(read_index), int'(ri));
    endtask

    task automatic check_reset_outputs(input string name);
        check({name, ".we"},   int'(write_enable),  0);
        check({name, ".addr"}, int'(write_address), 0);
        check({name, ".data"}, int'(write_sample),  0);
        check({name, ".ri"},   int'(read_index),    0);
    endtask

    // Assert reset between clock edges and check outputs before any edge arrives
    task automatic async_reset(input string name);
        @(negedge clk);
        new_sample_ready  = 1'b0;
        wave_display_idle = 1'b0;
        #1 reset = 1'b0;
        #1 check_reset_outputs(name);
        @(negedge clk);
        reset = 1'b1;
    endtask

    initial begin
        logic [17:0] ramp;
        total = 0;
        bad   = 0;
        reset = 1'b0;
        new_sample_ready  = 1'b0;
        new_sample_in     = '0;
        wave_display_idle = 1'b0;

        tbl[0] = '{1'b1, 18'h3FFFB, 1'b0, 1'b0, 9'h000, 8'h00, 1'b0}; // -5: no crossing
        tbl[1] = '{1'b1, 18'h3FFFF, 1'b0, 1'b0, 9'h000, 8'h00, 1'b0}; // -1
        tbl[2] = '{1'b1, 18'h00000, 1'b0, 1'b1, 9'h100, 8'h80, 1'b0}; // 0: crossing
        tbl[3] = '{1'b0, 18'h00000, 1'b1, 1'b0, 9'h000, 8'h00, 1'b0}; // idle in ACTIVE, no strobe
        tbl[4] = '{1'b1, 18'h00400, 1'b1, 1'b1, 9'h101, 8'h81, 1'b0};
        tbl[5] = '{1'b1, 18'h3FFFB, 1'b0, 1'b1, 9'h102, 8'h7F, 1'b0}; // back-to-back

        #1 check_reset_outputs("por");
        #20;
        @(negedge clk);
        reset = 1'b1;

        for (int i = 0; i < 6; i++) begin
            step($sformatf("tbl%0d", i), tbl[i].ready, tbl[i].s, tbl[i].idle,
                 tbl[i].we, tbl[i].addr, tbl[i].data, tbl[i].ri);
        end

        // Rest of the first capture: ramp i<<10 stores i with MSB flipped
        for (int i = 3; i < 256; i++) begin
            ramp = 18'(i << 10);
            step($sformatf("cap1_%0d", i), 1'b1, ramp, 1'b0,
                 1'b1, 9'(9'h100 + i), 8'(i ^ 8'h80), 1'b0);
        end

        // WAIT: no writes while the display is busy, even on a crossing
        step("wait_nostb", 1'b0, 18'h00000, 1'b0, 1'b0, 9'h0, 8'h0, 1'b0);
        step("wait_neg",   1'b1, 18'h3FFF9, 1'b0, 1'b0, 9'h0, 8'h0, 1'b0);
        step("wait_cross", 1'b1, 18'h00800, 1'b0, 1'b0, 9'h0, 8'h0, 1'b0);
        step("wait_neg2",  1'b1, 18'h3FFFF, 1'b0, 1'b0, 9'h0, 8'h0, 1'b0);

        // Idle and a -3 strobe together: swap, sample ignored but its sign kept
        step("swap_stb", 1'b1, 18'h3FFFD, 1'b1, 1'b0, 9'h0, 8'h0, 1'b1);
        step("cap2_0",   1'b1, 18'h00002, 1'b0, 1'b1, 9'h000, 8'h80, 1'b1);
        for (int i = 1; i < 256; i++) begin
            ramp = 18'(i << 10);
            step($sformatf("cap2_%0d", i), 1'b1, ramp, 1'b1,
                 1'b1, 9'(i), 8'(i ^ 8'h80), 1'b1);
        end
        step("cap2_done", 1'b1, 18'h00400, 1'b0, 1'b0, 9'h0, 8'h0, 1'b1);

        // Reset while read_index is 1
        async_reset("rst_wait");

        // Positive-only stream never arms a capture
        for (int i = 0; i < 1000; i++) begin
            ramp = 18'($urandom_range(0, 18'h1FFFF));
            step($sformatf("pos_%0d", i), 1'b1, ramp, 1'($urandom_range(0, 1)),
                 1'b0, 9'h0, 8'h0, 1'b0);
        end

        // Partial capture aborted by reset, then a fresh capture restarts at index 0
        step("cap3_neg", 1'b1, 18'h3FFFF, 1'b0, 1'b0, 9'h0,   8'h0,  1'b0);
        step("cap3_0",   1'b1, 18'h00000, 1'b0, 1'b1, 9'h100, 8'h80, 1'b0);
        step("cap3_1",   1'b1, 18'h00400, 1'b0, 1'b1, 9'h101, 8'h81, 1'b0);
        async_reset("rst_mid");
        step("post_pos", 1'b1, 18'h00400, 1'b0, 1'b0, 9'h0,   8'h0,  1'b0);
        step("post_neg", 1'b1, 18'h3FFFF, 1'b0, 1'b0, 9'h0,   8'h0,  1'b0);
        step("post_0",   1'b1, 18'h00800, 1'b0, 1'b1, 9'h100, 8'h82, 1'b0);
        step("post_idle", 1'b0, 18'h00800, 1'b0, 1'b0, 9'h0,  8'h0,  1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
